// File: rtl/rate_tick_gen.sv
// Timebase generator: 1 kHz and 1 Hz clock enables plus a selectable-rate tick and
// blink phase. The selected rate only changes at a period boundary.
module rate_tick_gen #(
    parameter int CLK_HZ        = 1_000_000,
    parameter int MIN_PERIOD_MS = 2000,
    parameter int NUM_RATES     = 4,
    parameter int SEL_W         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [SEL_W-1:0] sw,
    output logic             tick_1khz,
    output logic             tick_1hz,
    output logic             tick_sel,
    output logic             phase_sel,
    output logic [SEL_W-1:0] sel_active
);

    localparam int P      = CLK_HZ / 1000;
    localparam int PRE_W  = (P > 1) ? $clog2(P) : 1;
    localparam int HMAX   = MIN_PERIOD_MS / 2;
    localparam int H_W    = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam int SLOWEST_FAST = MIN_PERIOD_MS >> (NUM_RATES - 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(P - 1);
    localparam logic [9:0]       S_LAST   = 10'd999;
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NUM_RATES - 1);

    if ((CLK_HZ < 1000) || ((CLK_HZ % 1000) != 0)) begin : g_bad_clk_hz
        $error("rate_tick_gen: CLK_HZ must be a positive multiple of 1000");
    end
    if ((SLOWEST_FAST < 2) || ((SLOWEST_FAST % 2) != 0)) begin : g_bad_min_period
        $error("rate_tick_gen: fastest rate period must be even and at least 2 ms");
    end

    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
        if (s > SEL_MAX) begin
            return SEL_MAX;
        end else begin
            return s;
        end
    endfunction

    // Terminal h_cnt value for the half-period of rate index s.
    function automatic logic [H_W-1:0] half_last(input logic [SEL_W-1:0] s);
        int unsigned h;
        h = (MIN_PERIOD_MS >> s) / 32'd2;
        return H_W'(h - 32'd1);
    endfunction

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [9:0]       s_cnt_q, s_cnt_d;
    logic [H_W-1:0]   h_cnt_q, h_cnt_d;
    logic             khz_evt_q, khz_evt_d;
    logic             tick_1khz_q, tick_1khz_d;
    logic             tick_1hz_q, tick_1hz_d;
    logic             tick_sel_q, tick_sel_d;
    logic             phase_q, phase_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    logic pre_wrap_s;
    logic s_wrap_s;
    logic h_wrap_s;

    assign pre_wrap_s = (pre_cnt_q == PRE_LAST);
    assign s_wrap_s   = (s_cnt_q == S_LAST);
    assign h_wrap_s   = (h_cnt_q == half_last(sel_q));

    // Next-state logic for prescaler, 1 Hz counter and selected-rate phase.
    // khz_evt_q is the internal copy of the 1 kHz event; unlike the output pulse
    // it survives a pause so the derived counters never miss it.
    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        s_cnt_d     = s_cnt_q;
        h_cnt_d     = h_cnt_q;
        khz_evt_d   = khz_evt_q;
        phase_d     = phase_q;
        sel_d       = sel_q;
        tick_1khz_d = 1'b0;
        tick_1hz_d  = 1'b0;
        tick_sel_d  = 1'b0;
        if (clr) begin
            pre_cnt_d = '0;
            s_cnt_d   = '0;
            h_cnt_d   = '0;
            khz_evt_d = 1'b0;
            phase_d   = 1'b0;
            sel_d     = clamp_sel(sw);
        end else if (en) begin
            khz_evt_d   = pre_wrap_s;
            tick_1khz_d = pre_wrap_s;
            if (pre_wrap_s) begin
                pre_cnt_d = '0;
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
            if (khz_evt_q) begin
                tick_1hz_d = s_wrap_s;
                if (s_wrap_s) begin
                    s_cnt_d = '0;
                end else begin
                    s_cnt_d = s_cnt_q + 10'd1;
                end
                if (h_wrap_s) begin
                    h_cnt_d    = '0;
                    phase_d    = ~phase_q;
                    tick_sel_d = ~phase_q;
                    // A falling phase closes the period: adopt the requested rate.
                    if (phase_q) begin
                        sel_d = clamp_sel(sw);
                    end else begin
                        sel_d = sel_q;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + H_W'(1);
                end
            end else begin
                s_cnt_d = s_cnt_q;
                h_cnt_d = h_cnt_q;
            end
        end else begin
            pre_cnt_d = pre_cnt_q;
            khz_evt_d = khz_evt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt_q   <= '0;
            s_cnt_q     <= '0;
            h_cnt_q     <= '0;
            khz_evt_q   <= 1'b0;
            tick_1khz_q <= 1'b0;
            tick_1hz_q  <= 1'b0;
            tick_sel_q  <= 1'b0;
            phase_q     <= 1'b0;
            sel_q       <= '0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            s_cnt_q     <= s_cnt_d;
            h_cnt_q     <= h_cnt_d;
            khz_evt_q   <= khz_evt_d;
            tick_1khz_q <= tick_1khz_d;
            tick_1hz_q  <= tick_1hz_d;
            tick_sel_q  <= tick_sel_d;
            phase_q     <= phase_d;
            sel_q       <= sel_d;
        end
    end

    assign tick_1khz  = tick_1khz_q;
    assign tick_1hz   = tick_1hz_q;
    assign tick_sel   = tick_sel_q;
    assign phase_sel  = phase_q;
    assign sel_active = sel_q;

endmodule

// File: tb/tb_rate_tick_gen.sv
// Directed bench for rate_tick_gen with P=8 and MIN_PERIOD_MS=16 (H = 8/4/2/1).
// A second instance with NUM_RATES=3 covers select clamping.
module tb_rate_tick_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] sw;
    logic [1:0] sw_b;

    logic       tick_1khz, tick_1hz, tick_sel, phase_sel;
    logic [1:0] sel_active;
    logic       tick_1khz_b, tick_1hz_b, tick_sel_b, phase_sel_b;
    logic [1:0] sel_active_b;

    int n_tests = 0;
    int n_fail  = 0;

    rate_tick_gen #(
        .CLK_HZ(8000), .MIN_PERIOD_MS(16), .NUM_RATES(4), .SEL_W(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sw(sw),
        .tick_1khz(tick_1khz), .tick_1hz(tick_1hz), .tick_sel(tick_sel),
        .phase_sel(phase_sel), .sel_active(sel_active)
    );

    rate_tick_gen #(
        .CLK_HZ(8000), .MIN_PERIOD_MS(16), .NUM_RATES(3), .SEL_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sw(sw_b),
        .tick_1khz(tick_1khz_b), .tick_1hz(tick_1hz_b), .tick_sel(tick_sel_b),
        .phase_sel(phase_sel_b), .sel_active(sel_active_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_sel(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (tick_sel !== 1'b1 && n < bound);
    endtask

    task automatic run_until_fall(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (phase_sel !== 1'b0 && n < bound);
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // From the edge just before cycle 1: first 1 kHz tick at 8, first tick_sel at 65 (H=8).
    task automatic restart_check(input string tag);
        int n;
        repeat (7) tick();
        chk({tag, "_khz_c7"}, int'(tick_1khz), 0);
        tick();
        chk({tag, "_khz_c8"}, int'(tick_1khz), 1);
        run_until_sel(200, n);
        chk({tag, "_sel_first"}, n, 57);
    endtask

    initial begin
        int nk, first_hz, first_sel, n, hi, lo, viol;
        rst = 1'b0; en = 1'b1; clr = 1'b0; sw = 2'd0; sw_b = 2'd3;

        // 1. reset and base ticks
        repeat (3) tick();
        chk("rst_khz", int'(tick_1khz), 0);
        chk("rst_hz", int'(tick_1hz), 0);
        chk("rst_sel", int'(tick_sel), 0);
        chk("rst_phase", int'(phase_sel), 0);
        chk("rst_active", int'(sel_active), 0);
        chk("rst_active_b", int'(sel_active_b), 0);
        rst = 1'b1;
        repeat (7) tick();
        chk("khz_c7", int'(tick_1khz), 0);
        tick();
        chk("khz_c8", int'(tick_1khz), 1);
        tick();
        chk("khz_c9_width", int'(tick_1khz), 0);
        nk = 0; first_hz = 0; first_sel = 0;
        for (int c = 10; c <= 8001; c++) begin
            tick();
            if (tick_1khz === 1'b1) nk++;
            if (tick_1hz === 1'b1 && first_hz == 0) first_hz = c;
            if (tick_sel === 1'b1 && first_sel == 0) first_sel = c;
        end
        chk("khz_count", nk, 999);
        chk("hz_first", first_hz, 8001);
        chk("sel_first_boot", first_sel, 65);
        tick();
        chk("hz_width", int'(tick_1hz), 0);

        // 2. rate sweep
        for (int s = 0; s < 4; s++) begin
            sw = 2'(s);
            clr_pulse();
            chk($sformatf("sweep%0d_active", s), int'(sel_active), s);
            run_until_sel(400, n);
            chk($sformatf("sweep%0d_first", s), n, (64 >> s) + 1);
            run_until_fall(400, hi);
            chk($sformatf("sweep%0d_high", s), hi, 64 >> s);
            run_until_sel(400, lo);
            chk($sformatf("sweep%0d_spacing", s), hi + lo, 128 >> s);
        end

        // 3. mid-period switch 0 -> 3
        sw = 2'd0;
        clr_pulse();
        run_until_sel(400, n);
        chk("mid_first", n, 65);
        repeat (40) tick();
        chk("mid_active_before", int'(sel_active), 0);
        sw = 2'd3;
        run_until_fall(400, hi);
        chk("mid_high_rest", hi, 24);
        chk("mid_active_after", int'(sel_active), 3);
        run_until_sel(400, lo);
        chk("mid_low_new", lo, 8);
        run_until_fall(400, hi);
        run_until_sel(400, lo);
        chk("mid_spacing_new", hi + lo, 16);

        // 4. pause 37 cycles starting right after a 1 kHz tick
        sw = 2'd1;
        clr_pulse();
        run_until_sel(400, n);
        chk("pause_first", n, 33);
        repeat (7) tick();
        chk("pause_khz_c40", int'(tick_1khz), 1);
        en = 1'b0;
        viol = 0;
        for (int i = 0; i < 37; i++) begin
            tick();
            if (tick_1khz !== 1'b0 || tick_1hz !== 1'b0 || tick_sel !== 1'b0) viol++;
            if (phase_sel !== 1'b1) viol++;
        end
        chk("pause_quiet", viol, 0);
        en = 1'b1;
        run_until_sel(400, n);
        chk("pause_delay", n, 57);

        // 5a. clr on edge with pre_cnt=7, h_cnt=H-1
        sw = 2'd0;
        clr_pulse();
        repeat (63) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_khz", int'(tick_1khz), 0);
        chk("clr_sel", int'(tick_sel), 0);
        chk("clr_phase", int'(phase_sel), 0);
        restart_check("clr_restart");

        // 5b. reset on the same kind of edge, from rate 1
        sw = 2'd1;
        clr_pulse();
        repeat (31) tick();
        sw = 2'd0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_mid_khz", int'(tick_1khz), 0);
        chk("rst_mid_sel", int'(tick_sel), 0);
        chk("rst_mid_phase", int'(phase_sel), 0);
        chk("rst_mid_active", int'(sel_active), 0);
        restart_check("rst_restart");

        // 6. out-of-range select clamps to 2 on the NUM_RATES=3 instance
        clr_pulse();
        chk("clamp_active", int'(sel_active_b), 2);
        n = 0;
        do begin
            tick();
            n++;
        end while (tick_sel_b !== 1'b1 && n < 200);
        chk("clamp_first", n, 17);
        n = 0;
        do begin
            tick();
            n++;
        end while (tick_sel_b !== 1'b1 && n < 200);
        chk("clamp_spacing", n, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rate_tick_gen.md
# rate_tick_gen

Parametrised timebase generator for the hourglass datapath. It derives a 1 kHz tick, a 1 Hz tick, and a run-time-selectable rate tick from one system clock. All outputs are single-cycle clock enables or registered square waves in the `clk` domain, never derived clocks. Rate changes apply only at period boundaries, and counting can be paused.

## Interface
- `CLK_HZ`, default 1_000_000: system clock frequency. Must be a multiple of 1000.
- `MIN_PERIOD_MS`, default 2000: period of the slowest selectable rate (sel = 0). Rate k has period `MIN_PERIOD_MS >> k` ms.
- `NUM_RATES`, default 4: number of selectable rates.
- `SEL_W`, default 2: width of `sw`, equal to `clog2(NUM_RATES)`.

Ports:
- `clk` — in — 1 — system clock. Single clock domain.
- `rst` — in — 1 — reset, synchronous, active-low. All state clears on a `clk` edge while `rst` = 0.
- `en` — in — 1 — count enable. 0 freezes all counters and phase.
- `clr` — in — 1 — synchronous restart of all counters. Has no effect on `sw` sampling rules other than those stated under Operation.
- `sw` — in — `SEL_W` — requested rate index. Values ≥ `NUM_RATES` clamp to `NUM_RATES`-1.
- `tick_1khz` — out — 1 — one-cycle pulse every `CLK_HZ`/1000 cycles.
- `tick_1hz` — out — 1 — one-cycle pulse every 1000 `tick_1khz`.
- `tick_sel` — out — 1 — one-cycle pulse once per selected period.
- `phase_sel` — out — 1 — 50 % square wave at the selected rate, for display blink.
- `sel_active` — out — `SEL_W` — rate index currently in effect.

## Operation
- **Prescaler.** `pre_cnt` counts 0..P-1, with P = `CLK_HZ`/1000, and wraps to 0. On the wrap it registers `tick_1khz` = 1.
- **1 Hz path.** `s_cnt` counts `tick_1khz` pulses 0..999 and wraps. On the wrap it registers `tick_1hz` = 1.
- **Selected-rate path.**
  - H = (`MIN_PERIOD_MS` >> `sel_active`)/2, the half-period in ms.
  - `h_cnt` counts `tick_1khz` pulses 0..H-1.
  - On the `tick_1khz` where `h_cnt` = H-1: `h_cnt` ← 0 and `phase_sel` toggles.
  - On a 0→1 toggle: `tick_sel` = 1 in the same registered cycle as the `phase_sel` rise.
  - On a 1→0 toggle (period end): `sel_active` ← clamped `sw`.
- **Rate changes.** A change on `sw` mid-period never shortens or stretches the current period. The new H takes effect from the next period, so `phase_sel` has no runt pulses.
- **Pause (`en` = 0).**
  - `pre_cnt`, `s_cnt`, `h_cnt`, and `phase_sel` hold.
  - All tick outputs are 0.
  - On resume, counting continues from the held values. No tick is lost or duplicated.
- **Restart (`clr` = 1, while `rst` = 1).**
  - All counters ← 0, `phase_sel` ← 0, all ticks ← 0.
  - `sel_active` ← clamped `sw` immediately.
  - `clr` has priority over `en`.
- **Priority.** `rst` > `clr` > `en`.
- **Elaboration checks.** Elaboration fails if `CLK_HZ` % 1000 ≠ 0, or if `MIN_PERIOD_MS` >> (`NUM_RATES`-1) is < 2 or odd.
- **Counter widths.** `pre_cnt` is `clog2(P)`. `h_cnt` is `clog2(MIN_PERIOD_MS/2)`. `s_cnt` is 10 bits.

## Timing
- **Reset values.** `tick_1khz`, `tick_1hz`, `tick_sel` = 0; `phase_sel` = 0; `sel_active` = 0. All counters = 0.
- **First `tick_1khz`.** High in cycle P after the first edge with `rst` = 1 and `en` = 1. That edge is cycle 1.
- **Pulse width.** Every tick is high for exactly 1 cycle.
- **Derived tick latency.** `tick_1hz` and `tick_sel` are registered off the qualifying `tick_1khz`, so they rise 1 cycle after it.
- **`tick_sel` spacing.** Steady-state spacing is 2·H·P cycles. The first `tick_sel` after reset or `clr` comes at cycle H·P+1.
- **Rate update.** `sel_active` updates on the same edge as the `phase_sel` 1→0 transition. The new H applies to the immediately following half-period.
- **Reset mid-operation.** Outputs return to reset values on the next edge. No pulse is emitted on that edge.
- **Simultaneous events.**
  - `clr` on the same edge as a pending wrap suppresses that wrap's tick.
  - A `sw` change on the period-end edge is captured, since `sw` is sampled on that edge.

## Test plan
Bench parameters: `CLK_HZ`=8000 (P=8) and `MIN_PERIOD_MS`=16, which give periods of 16/8/4/2 ms and H = 8/4/2/1.

1. **Reset and base ticks.** Hold `rst` = 0 for 3 cycles, then release with `sw`=0 and `en`=1. Required: all outputs 0 during reset; `tick_1khz` at cycles 8, 16, 24, … with width 1; first `tick_1hz` at cycle 8001.
2. **Rate sweep.** For each `sw` in 0..3, apply `clr`. Required: `tick_sel` spacing 128, 64, 32, 16 cycles; `phase_sel` high and low for 64, 32, 16, 8 cycles respectively.
3. **Mid-period switch.** Run with `sw`=0, then set `sw`=3 at cycle 40 of a period. Required: the current 128-cycle period completes unchanged; `sel_active` becomes 3 at the `phase_sel` fall; the next `tick_sel` spacing is 16; no runt `phase_sel` pulse.
4. **Pause.** With `sw`=1, deassert `en` for 37 cycles mid half-period. Required: no ticks while paused; the next `tick_sel` is delayed by exactly 37 cycles relative to an unpaused reference run.
5. **Clear and reset mid-run.**
   - Assert `clr` on the edge where `pre_cnt`=7 and `h_cnt`=H-1. Required: no tick that edge; `phase_sel`=0; restart timing matches scenario 1.
   - Repeat with `rst` = 0 instead of `clr`. Required: the same result.
6. **Out-of-range select.** Set `NUM_RATES`=3 and `sw`=3. Required: `sel_active`=2 and `tick_sel` spacing 32 cycles.
